clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 109 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: idle hold-off, gating, and timed wake handshake.
// Outputs are registered/decoded from state only, so there is no input-to-output path.
module clk_gate_ctrl #(
  parameter int DLY_W    = 8,
  parameter int CNT_W    = 16,
  parameter int WAKE_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             busy_i,
  input  logic             sleep_req_i,
  input  logic             wake_req_i,
  input  logic             force_on_i,
  input  logic [DLY_W-1:0] idle_dly_i,
  input  logic             clr_cnt_i,
  output logic             clk_en_o,
  output logic             sleep_ack_o,
  output logic             wake_ack_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] gated_cnt_o
);

  localparam int WK_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WK_W-1:0] WK_LOAD = WK_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [WK_W-1:0]  wk_q, wk_d;
  logic             ack_q, ack_d;
  logic             wake_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wk_d    = wk_q;
    ack_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (sleep_req_i && !busy_i && !force_on_i && !wake_req_i) begin
          state_d = IDLE_WAIT;
          dly_d   = idle_dly_i;
        end
        // edge-detect so a held request acknowledges only once
        ack_d = wake_req_i && !wake_q;
      end
      IDLE_WAIT: begin
        if (busy_i || wake_req_i || force_on_i || !sleep_req_i) begin
          state_d = RUN;
          ack_d   = wake_req_i;
        end else if (dly_q == '0) begin
          state_d = GATED;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      GATED: begin
        if (wake_req_i || busy_i || force_on_i) begin
          state_d = WAKE;
          wk_d    = WK_LOAD;
        end
      end
      WAKE: begin
        if (wk_q == '0) begin
          state_d = RUN;
          ack_d   = 1'b1;
        end else begin
          wk_d = wk_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      dly_q   <= '0;
      wk_q    <= '0;
      ack_q   <= 1'b0;
      wake_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wk_q    <= wk_d;
      ack_q   <= ack_d;
      wake_q  <= wake_req_i;
      if (clr_cnt_i)
        cnt_q <= '0;
      else if (state_q == GATED && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign clk_en_o    = (state_q != GATED);
  assign sleep_ack_o = (state_q == GATED);
  assign wake_ack_o  = ack_q;
  assign state_o     = state_q;
  assign gated_cnt_o = cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl; a CNT_W=4 copy shares the inputs to observe saturation.
module tb_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, busy, sleep_req, wake_req, force_on, clr_cnt;
  logic [7:0]  idle_dly;
  logic        clk_en, sleep_ack, wake_ack;
  logic [1:0]  state;
  logic [15:0] gated_cnt;
  logic        clk_en4, sleep_ack4, wake_ack4;
  logic [1:0]  state4;
  logic [3:0]  gated_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(.DLY_W(8), .CNT_W(16), .WAKE_LAT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .busy_i(busy), .sleep_req_i(sleep_req),
    .wake_req_i(wake_req), .force_on_i(force_on), .idle_dly_i(idle_dly),
    .clr_cnt_i(clr_cnt), .clk_en_o(clk_en), .sleep_ack_o(sleep_ack),
    .wake_ack_o(wake_ack), .state_o(state), .gated_cnt_o(gated_cnt)
  );

  clk_gate_ctrl #(.DLY_W(8), .CNT_W(4), .WAKE_LAT(2)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .busy_i(busy), .sleep_req_i(sleep_req),
    .wake_req_i(wake_req), .force_on_i(force_on), .idle_dly_i(idle_dly),
    .clr_cnt_i(clr_cnt), .clk_en_o(clk_en4), .sleep_ack_o(sleep_ack4),
    .wake_ack_o(wake_ack4), .state_o(state4), .gated_cnt_o(gated_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; busy = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;
    force_on = 1'b0; clr_cnt = 1'b0; idle_dly = 8'd0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_clk_en", 32'(clk_en), 1);
    chk("rst_sleep_ack", 32'(sleep_ack), 0);
    chk("rst_wake_ack", 32'(wake_ack), 0);
    chk("rst_cnt", 32'(gated_cnt), 0);
    rst_n = 1'b1;
    tick();

    // idle_dly=3: four IDLE_WAIT cycles, then gated; mid-wait idle_dly change ignored
    idle_dly = 8'd3; sleep_req = 1'b1;
    tick();
    idle_dly = 8'd0;
    chk("iw1_state", 32'(state), 1);
    chk("iw1_clk_en", 32'(clk_en), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("iw_state", 32'(state), 1);
      chk("iw_clk_en", 32'(clk_en), 1);
    end
    tick();
    chk("gate_state", 32'(state), 2);
    chk("gate_clk_en", 32'(clk_en), 0);
    chk("gate_sleep_ack", 32'(sleep_ack), 1);
    chk("gate_cnt0", 32'(gated_cnt), 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("gated_clk_en", 32'(clk_en), 0);
    end
    chk("cnt19", 32'(gated_cnt), 19);

    // wake after 20 gated cycles
    wake_req = 1'b1;
    tick();
    chk("wake1_state", 32'(state), 3);
    chk("wake1_clk_en", 32'(clk_en), 1);
    chk("wake1_sleep_ack", 32'(sleep_ack), 0);
    chk("wake1_ack", 32'(wake_ack), 0);
    chk("wake1_cnt", 32'(gated_cnt), 20);
    chk("cnt4_sat_a", 32'(gated_cnt4), 15);
    tick();
    chk("wake2_state", 32'(state), 3);
    chk("wake2_ack", 32'(wake_ack), 0);
    tick();
    chk("run_state", 32'(state), 0);
    chk("run_ack", 32'(wake_ack), 1);
    tick();
    chk("ack_single", 32'(wake_ack), 0);
    chk("held_wake_state", 32'(state), 0);
    chk("cnt_after_wake", 32'(gated_cnt), 20);
    wake_req = 1'b0; sleep_req = 1'b0;
    tick();

    // wake_req rising in RUN: one pulse even if held
    wake_req = 1'b1;
    tick();
    chk("run_wake_ack", 32'(wake_ack), 1);
    tick();
    chk("run_wake_held", 32'(wake_ack), 0);
    wake_req = 1'b0;
    tick();

    // clear in RUN
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_run", 32'(gated_cnt), 0);

    // busy pulse during IDLE_WAIT aborts to RUN
    idle_dly = 8'd3; sleep_req = 1'b1;
    tick();
    chk("ab_iw1", 32'(state), 1);
    tick();
    chk("ab_iw2", 32'(state), 1);
    busy = 1'b1;
    tick();
    chk("ab_run", 32'(state), 0);
    chk("ab_clk_en", 32'(clk_en), 1);
    busy = 1'b0; sleep_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ab_clk_en_hold", 32'(clk_en), 1);
    end
    chk("ab_cnt", 32'(gated_cnt), 0);

    // wake_req in IDLE_WAIT aborts with acknowledge
    idle_dly = 8'd5; sleep_req = 1'b1;
    tick();
    chk("iww_state", 32'(state), 1);
    wake_req = 1'b1;
    tick();
    chk("iww_run", 32'(state), 0);
    chk("iww_ack", 32'(wake_ack), 1);
    wake_req = 1'b0; sleep_req = 1'b0;
    tick();
    chk("iww_ack_end", 32'(wake_ack), 0);

    // saturation, then clear while gated
    idle_dly = 8'd0; sleep_req = 1'b1;
    tick();
    chk("d0_iw", 32'(state), 1);
    tick();
    chk("d0_gated", 32'(state), 2);
    sleep_req = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("sat_state", 32'(state), 2);
    chk("cnt30", 32'(gated_cnt), 30);
    chk("cnt4_sat", 32'(gated_cnt4), 15);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt", 32'(gated_cnt), 0);
    chk("clr_cnt4", 32'(gated_cnt4), 0);
    tick();
    chk("resume_cnt", 32'(gated_cnt), 1);
    chk("resume_cnt4", 32'(gated_cnt4), 1);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    chk("busy_wake", 32'(state), 3);
    tick(); tick();
    chk("busy_run", 32'(state), 0);
    chk("busy_ack", 32'(wake_ack), 1);

    // force_on holds RUN against sleep_req
    force_on = 1'b1; sleep_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("force_state", 32'(state), 0);
      chk("force_clk_en", 32'(clk_en), 1);
    end

    // reset while gated
    force_on = 1'b0;
    tick(); tick();
    chk("pre_rst_gated", 32'(state), 2);
    tick(); tick();
    rst_n = 1'b0; sleep_req = 1'b0;
    tick();
    chk("grst_state", 32'(state), 0);
    chk("grst_clk_en", 32'(clk_en), 1);
    chk("grst_cnt", 32'(gated_cnt), 0);
    chk("grst_ack", 32'(wake_ack), 0);
    chk("grst_sleep_ack", 32'(sleep_ack), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_ack", 32'(wake_ack), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
